// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the word-copy DMA engine.
package mem_dma_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      FIN   = 2'd3
   } state_t;

   localparam int unsigned WORD_BYTES = 4;

   // A job is rejected if either base address is not word aligned.
   function automatic logic misaligned(input logic [1:0] src_lo, input logic [1:0] dst_lo);
      return (src_lo | dst_lo) != 2'b00;
   endfunction

endpackage

// File: rtl/mem_dma.sv
// Word-by-word memory copy engine: one READ then one WRITE per word, ascending addresses.
// Handshake: start is honoured only in IDLE; done pulses for one cycle in FIN, busy covers READ..FIN.
module mem_dma
   import mem_dma_pkg::*;
#(
   parameter int LEN_W = 8,
   parameter int AW    = 32
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [AW-1:0]    src_base,
   input  logic [AW-1:0]    dst_base,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [LEN_W-1:0] xfer_count,
   output logic             mem_we,
   output logic [AW-1:0]    mem_a,
   output logic [31:0]      mem_wd,
   input  logic [31:0]      mem_rd,
   output state_t           state
);

   localparam logic [AW-1:0]    STEP = AW'(WORD_BYTES);
   localparam logic [LEN_W-1:0] ONE  = LEN_W'(1);

   logic [AW-1:0]    src_ptr;
   logic [AW-1:0]    dst_ptr;
   logic [AW-1:0]    src_nxt;
   logic [AW-1:0]    dst_nxt;
   logic [LEN_W-1:0] len_q;
   logic [LEN_W-1:0] count_nxt;

   assign src_nxt   = src_ptr + STEP;
   assign dst_nxt   = dst_ptr + STEP;
   assign count_nxt = xfer_count + ONE;

   // Memory-facing outputs are registered and set up one state ahead, so
   // mem_a is already valid when READ/WRITE begins; mem_wd doubles as the data register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         src_ptr    <= '0;
         dst_ptr    <= '0;
         len_q      <= '0;
         xfer_count <= '0;
         err        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         mem_we     <= 1'b0;
         mem_a      <= '0;
         mem_wd     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  src_ptr    <= src_base;
                  dst_ptr    <= dst_base;
                  len_q      <= len;
                  xfer_count <= '0;
                  err        <= 1'b0;
                  busy       <= 1'b1;
                  if (misaligned(src_base[1:0], dst_base[1:0])) begin
                     err   <= 1'b1;
                     done  <= 1'b1;
                     state <= FIN;
                  end else if (len == '0) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     mem_a <= src_base;
                     state <= READ;
                  end
               end
            end
            READ: begin
               mem_wd <= mem_rd;
               mem_a  <= dst_ptr;
               mem_we <= 1'b1;
               state  <= WRITE;
            end
            WRITE: begin
               src_ptr    <= src_nxt;
               dst_ptr    <= dst_nxt;
               xfer_count <= count_nxt;
               mem_we     <= 1'b0;
               mem_wd     <= '0;
               if (count_nxt == len_q) begin
                  mem_a <= '0;
                  done  <= 1'b1;
                  state <= FIN;
               end else begin
                  mem_a <= src_nxt;
                  state <= READ;
               end
            end
            FIN: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
